// File: rtl/jtkiwi_rom_pkg.sv
// Shared types and constants for the Kiwi graphics ROM responder.
// FSM states, slot indices and datapath widths.
package jtkiwi_rom_pkg;

  localparam int CLI_AW = 18;
  localparam int BA_AW  = 22;
  localparam int DW     = 32;

  localparam logic SLOT_SCR = 1'b0;
  localparam logic SLOT_OBJ = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

endpackage

// File: rtl/jtkiwi_gfx_rom_if.sv
// SDRAM bank port between the ROM responder and the controller.
// master drives the request, slave answers it.
interface jtkiwi_gfx_rom_if;
  import jtkiwi_rom_pkg::*;

  logic [BA_AW-1:0] ba_addr;
  logic             ba_rd;
  logic             ba_ack;
  logic             ba_rdy;
  logic [DW-1:0]    data_read;

  modport master (
    output ba_addr, ba_rd,
    input  ba_ack, ba_rdy, data_read
  );

  modport slave (
    input  ba_addr, ba_rd,
    output ba_ack, ba_rdy, data_read
  );
endinterface

// File: rtl/jtkiwi_rom_slot.sv
// One-entry tag/data cache for a single ROM client.
// Also maps the client word address into the bank.
module jtkiwi_rom_slot
  import jtkiwi_rom_pkg::*;
#(
  parameter logic [BA_AW-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [CLI_AW-1:0] addr,
  input  logic              load,
  input  logic [CLI_AW-1:0] tag_in,
  input  logic [DW-1:0]     data_in,
  output logic              ok,
  output logic              pending,
  output logic [DW-1:0]     data,
  output logic [BA_AW-1:0]  ba_addr
);

  logic              valid;
  logic [CLI_AW-1:0] tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= tag_in;
      data  <= data_in;
    end
  end

  assign ok      = cs & valid & (tag == addr);
  assign pending = cs & ~ok;
  // 32-bit word to 16-bit word, wrapping in the bank
  assign ba_addr = BA_AW'({addr, 1'b0}) + OFFSET;

endmodule

// File: rtl/jtkiwi_gfx_rom.sv
// Graphics ROM responder: two cached clients sharing one bank port.
// Misses are granted round-robin, one transaction at a time.
module jtkiwi_gfx_rom
  import jtkiwi_rom_pkg::*;
#(
  parameter logic [BA_AW-1:0] SCR_OFFSET = 22'h00_0000,
  parameter logic [BA_AW-1:0] OBJ_OFFSET = 22'h10_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [19:2]       scr_addr,
  input  logic              scr_cs,
  output logic [DW-1:0]     scr_data,
  output logic              scr_ok,
  input  logic [19:2]       obj_addr,
  input  logic              obj_cs,
  output logic [DW-1:0]     obj_data,
  output logic              obj_ok,
  jtkiwi_gfx_rom_if.master  ba
);

  state_t            state, state_nx;
  logic              last, last_nx;
  logic              owner, owner_nx;
  logic [CLI_AW-1:0] req_tag, tag_nx;
  logic [BA_AW-1:0]  addr_r, addr_nx;
  logic              rd_r, rd_nx;
  logic              fill, gnt_obj;
  logic              scr_pend, obj_pend;
  logic [BA_AW-1:0]  scr_ba, obj_ba;

  jtkiwi_rom_slot #(.OFFSET(SCR_OFFSET)) u_scr (
    .clk     (clk),
    .rst     (rst),
    .cs      (scr_cs),
    .addr    (scr_addr),
    .load    (fill & (owner == SLOT_SCR)),
    .tag_in  (req_tag),
    .data_in (ba.data_read),
    .ok      (scr_ok),
    .pending (scr_pend),
    .data    (scr_data),
    .ba_addr (scr_ba)
  );

  jtkiwi_rom_slot #(.OFFSET(OBJ_OFFSET)) u_obj (
    .clk     (clk),
    .rst     (rst),
    .cs      (obj_cs),
    .addr    (obj_addr),
    .load    (fill & (owner == SLOT_OBJ)),
    .tag_in  (req_tag),
    .data_in (ba.data_read),
    .ok      (obj_ok),
    .pending (obj_pend),
    .data    (obj_data),
    .ba_addr (obj_ba)
  );

  // on a tie, obj wins only if scr was served last
  assign gnt_obj = obj_pend & (~scr_pend | (last == SLOT_SCR));

  always_comb begin
    state_nx = state;
    last_nx  = last;
    owner_nx = owner;
    tag_nx   = req_tag;
    addr_nx  = addr_r;
    rd_nx    = rd_r;
    fill     = 1'b0;
    unique case (state)
      IDLE: begin
        if (scr_pend | obj_pend) begin
          owner_nx = gnt_obj ? SLOT_OBJ : SLOT_SCR;
          tag_nx   = gnt_obj ? obj_addr : scr_addr;
          addr_nx  = gnt_obj ? obj_ba : scr_ba;
          rd_nx    = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ba.ba_ack) begin
          rd_nx = 1'b0;
          if (ba.ba_rdy) begin
            fill     = 1'b1;
            last_nx  = owner;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (ba.ba_rdy) begin
          fill     = 1'b1;
          last_nx  = owner;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= SLOT_OBJ;
      owner   <= SLOT_SCR;
      req_tag <= '0;
      addr_r  <= '0;
      rd_r    <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      owner   <= owner_nx;
      req_tag <= tag_nx;
      addr_r  <= addr_nx;
      rd_r    <= rd_nx;
    end
  end

  assign ba.ba_addr = addr_r;
  assign ba.ba_rd   = rd_r;

endmodule

// File: tb/tb_jtkiwi_gfx_rom.sv
// Directed bench for jtkiwi_gfx_rom.
// Inputs change 1ns after posedge, checks 1ns later.
module tb_jtkiwi_gfx_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] scr_addr, obj_addr;
  logic        scr_cs, obj_cs;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  int          n_cmp = 0;
  int          n_err = 0;

  jtkiwi_gfx_rom_if bif ();

  jtkiwi_gfx_rom dut (
    .clk      (clk),
    .rst      (rst),
    .scr_addr (scr_addr),
    .scr_cs   (scr_cs),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_addr (obj_addr),
    .obj_cs   (obj_cs),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .ba       (bif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    scr_addr = '0; obj_addr = '0;
    scr_cs = 1'b0; obj_cs = 1'b0;
    bif.ba_ack = 1'b0; bif.ba_rdy = 1'b0;
    bif.data_read = '0;
    tick(); tick();
    settle();
    chk("rst_ba_rd", 32'(bif.ba_rd), 32'd0);
    chk("rst_ba_addr", 32'(bif.ba_addr), 32'd0);
    chk("rst_scr_ok", 32'(scr_ok), 32'd0);
    chk("rst_obj_ok", 32'(obj_ok), 32'd0);
    chk("rst_scr_data", scr_data, 32'd0);
    chk("rst_obj_data", obj_data, 32'd0);

    // cold miss on scr, cycle N
    tick();
    rst = 1'b0;
    scr_addr = 18'h00010; scr_cs = 1'b1;
    settle();
    chk("miss_ok_n", 32'(scr_ok), 32'd0);
    tick(); settle();
    chk("miss_rd_n1", 32'(bif.ba_rd), 32'd1);
    chk("miss_addr_n1", 32'(bif.ba_addr), 32'h000020);
    tick(); settle();
    chk("miss_rd_n2", 32'(bif.ba_rd), 32'd1);
    tick();
    bif.ba_ack = 1'b1;
    settle();
    chk("miss_rd_n3", 32'(bif.ba_rd), 32'd1);
    tick();
    bif.ba_ack = 1'b0;
    settle();
    chk("miss_rd_n4", 32'(bif.ba_rd), 32'd0);
    tick(); tick();
    bif.ba_rdy = 1'b1; bif.data_read = 32'hDEADBEEF;
    settle();
    chk("miss_ok_n6", 32'(scr_ok), 32'd0);
    tick();
    bif.ba_rdy = 1'b0; bif.data_read = '0;
    settle();
    chk("miss_ok_n7", 32'(scr_ok), 32'd1);
    chk("miss_data_n7", scr_data, 32'hDEADBEEF);

    // hit after fill
    scr_cs = 1'b0;
    settle();
    chk("hit_cs0_ok", 32'(scr_ok), 32'd0);
    tick();
    scr_cs = 1'b1;
    settle();
    chk("hit_ok", 32'(scr_ok), 32'd1);
    tick(); settle();
    chk("hit_no_rd", 32'(bif.ba_rd), 32'd0);
    chk("hit_ok_held", 32'(scr_ok), 32'd1);

    // simultaneous misses after reset, same-cycle ack+rdy
    rst = 1'b1; scr_cs = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("rst2_scr_ok", 32'(scr_ok), 32'd0);
    scr_addr = 18'd1; obj_addr = 18'd2;
    scr_cs = 1'b1; obj_cs = 1'b1;
    tick(); settle();
    chk("tie1_rd", 32'(bif.ba_rd), 32'd1);
    chk("tie1_addr", 32'(bif.ba_addr), 32'h000002);
    bif.ba_ack = 1'b1; bif.ba_rdy = 1'b1;
    bif.data_read = 32'h11111111;
    tick();
    bif.ba_ack = 1'b0; bif.ba_rdy = 1'b0;
    settle();
    chk("same_rd_low", 32'(bif.ba_rd), 32'd0);
    chk("same_scr_ok", 32'(scr_ok), 32'd1);
    chk("same_scr_data", scr_data, 32'h11111111);
    tick(); settle();
    chk("tie2_rd", 32'(bif.ba_rd), 32'd1);
    chk("tie2_addr", 32'(bif.ba_addr), 32'h100004);
    bif.ba_ack = 1'b1; bif.ba_rdy = 1'b1;
    bif.data_read = 32'h22222222;
    tick();
    bif.ba_ack = 1'b0; bif.ba_rdy = 1'b0;
    settle();
    chk("tie2_obj_ok", 32'(obj_ok), 32'd1);
    chk("tie2_obj_data", obj_data, 32'h22222222);
    scr_addr = 18'd3; obj_addr = 18'd4;
    tick(); settle();
    chk("tie3_addr", 32'(bif.ba_addr), 32'h000006);
    bif.ba_ack = 1'b1; bif.ba_rdy = 1'b1;
    bif.data_read = 32'h33333333;
    tick();
    bif.ba_ack = 1'b0; bif.ba_rdy = 1'b0;
    tick(); settle();
    chk("tie4_addr", 32'(bif.ba_addr), 32'h100008);
    bif.ba_ack = 1'b1; bif.ba_rdy = 1'b1;
    bif.data_read = 32'h44444444;
    tick();
    bif.ba_ack = 1'b0; bif.ba_rdy = 1'b0;
    scr_cs = 1'b0; obj_cs = 1'b0;
    settle();
    chk("tie4_obj_data", obj_data, 32'h44444444);

    // address change during fetch
    tick();
    scr_addr = 18'h5; scr_cs = 1'b1;
    tick(); settle();
    chk("chg_addr1", 32'(bif.ba_addr), 32'h00000A);
    bif.ba_ack = 1'b1;
    tick();
    bif.ba_ack = 1'b0;
    scr_addr = 18'h6;
    tick();
    bif.ba_rdy = 1'b1; bif.data_read = 32'hAAAA5555;
    tick();
    bif.ba_rdy = 1'b0;
    settle();
    chk("chg_ok_low", 32'(scr_ok), 32'd0);
    chk("chg_stale_data", scr_data, 32'hAAAA5555);
    tick(); settle();
    chk("chg_rd2", 32'(bif.ba_rd), 32'd1);
    chk("chg_addr2", 32'(bif.ba_addr), 32'h00000C);
    bif.ba_ack = 1'b1; bif.ba_rdy = 1'b1;
    bif.data_read = 32'hBBBB6666;
    tick();
    bif.ba_ack = 1'b0; bif.ba_rdy = 1'b0;
    settle();
    chk("chg_ok", 32'(scr_ok), 32'd1);
    chk("chg_data", scr_data, 32'hBBBB6666);

    // reset during WAIT_RDY, late rdy ignored
    scr_cs = 1'b0;
    obj_addr = 18'h7; obj_cs = 1'b1;
    tick(); settle();
    chk("rr_addr", 32'(bif.ba_addr), 32'h10000E);
    bif.ba_ack = 1'b1;
    tick();
    bif.ba_ack = 1'b0;
    tick();
    rst = 1'b1; obj_cs = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("rr_rd", 32'(bif.ba_rd), 32'd0);
    chk("rr_scr_ok", 32'(scr_ok), 32'd0);
    chk("rr_obj_ok", 32'(obj_ok), 32'd0);
    bif.ba_rdy = 1'b1; bif.data_read = 32'hCCCCCCCC;
    tick();
    bif.ba_rdy = 1'b0;
    settle();
    chk("rr_no_fill", obj_data, 32'd0);
    obj_cs = 1'b1; scr_cs = 1'b1;
    settle();
    chk("rr_obj_miss", 32'(obj_ok), 32'd0);
    chk("rr_scr_miss", 32'(scr_ok), 32'd0);
    tick(); settle();
    chk("rr_fresh_rd", 32'(bif.ba_rd), 32'd1);
    chk("rr_fresh_addr", 32'(bif.ba_addr), 32'h00000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
